// File: rtl/pcie_axi_req_bridge.sv
// Bridges the PCIe sub-controller's single-outstanding RdRq/WrRq interface onto
// single-beat AXI4 master transactions, returning one-cycle completion pulses.
module pcie_axi_req_bridge #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            RdRqValid,
    input  logic [63:0]     RdRqAddr,
    output logic [127:0]    RdRqData,
    output logic            RdRqReady,
    output logic            RdRqErr,

    input  logic            WrRqValid,
    input  logic [63:0]     WrRqAddr,
    input  logic [127:0]    WrRqData,
    output logic            WrRqReady,
    output logic            WrRqErr,

    output logic [ID_W-1:0] m_arid,
    output logic [63:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic            m_arvalid,
    input  logic            m_arready,

    input  logic [ID_W-1:0] m_rid,
    input  logic [127:0]    m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready,

    output logic [ID_W-1:0] m_awid,
    output logic [63:0]     m_awaddr,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic            m_awvalid,
    input  logic            m_awready,

    output logic [127:0]    m_wdata,
    output logic [15:0]     m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,

    input  logic [ID_W-1:0] m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        RD_DONE = 3'd3,
        WR_REQ  = 3'd4,
        WR_RESP = 3'd5,
        WR_DONE = 3'd6
    } state_t;

    state_t        r_state,     w_state;
    logic [63:0]   r_araddr,    w_araddr;
    logic          r_arvalid,   w_arvalid;
    logic          r_rready,    w_rready;
    logic [127:0]  r_rdData,    w_rdData;
    logic          r_rdReady,   w_rdReady;
    logic          r_rdErr,     w_rdErr;
    logic          r_rdErrAcc,  w_rdErrAcc;
    logic          r_firstBeat, w_firstBeat;
    logic [63:0]   r_awaddr,    w_awaddr;
    logic          r_awvalid,   w_awvalid;
    logic [127:0]  r_wdata,     w_wdata;
    logic          r_wvalid,    w_wvalid;
    logic          r_bready,    w_bready;
    logic          r_wrReady,   w_wrReady;
    logic          r_wrErr,     w_wrErr;
    logic          w_rBeatErr;
    logic          w_bErr;

    // A read beat is bad on a non-OKAY response, a foreign ID, or any beat
    // beyond the single one we asked for (signalled by rlast arriving late).
    assign w_rBeatErr = (m_rresp != 2'b00) | (m_rid != AXI_ID) | ~m_rlast;
    assign w_bErr     = (m_bresp != 2'b00) | (m_bid != AXI_ID);

    always_comb begin
        w_state     = r_state;
        w_araddr    = r_araddr;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_rdData    = r_rdData;
        w_rdReady   = 1'b0;
        w_rdErr     = 1'b0;
        w_rdErrAcc  = r_rdErrAcc;
        w_firstBeat = r_firstBeat;
        w_awaddr    = r_awaddr;
        w_awvalid   = r_awvalid;
        w_wdata     = r_wdata;
        w_wvalid    = r_wvalid;
        w_bready    = r_bready;
        w_wrReady   = 1'b0;
        w_wrErr     = 1'b0;

        case (r_state)
            IDLE: begin
                if (RdRqValid) begin
                    w_araddr  = RdRqAddr;
                    w_arvalid = 1'b1;
                    w_state   = RD_ADDR;
                end else if (WrRqValid) begin
                    w_awaddr  = WrRqAddr;
                    w_wdata   = WrRqData;
                    w_awvalid = 1'b1;
                    w_wvalid  = 1'b1;
                    w_state   = WR_REQ;
                end
            end
            RD_ADDR: begin
                if (m_arready) begin
                    w_arvalid   = 1'b0;
                    w_rready    = 1'b1;
                    w_firstBeat = 1'b1;
                    w_rdErrAcc  = 1'b0;
                    w_state     = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid && r_rready) begin
                    w_firstBeat = 1'b0;
                    w_rdErrAcc  = r_rdErrAcc | w_rBeatErr;
                    if (r_firstBeat) begin
                        w_rdData = m_rdata;
                    end
                    if (m_rlast) begin
                        w_rready  = 1'b0;
                        w_rdReady = 1'b1;
                        w_rdErr   = r_rdErrAcc | w_rBeatErr;
                        w_state   = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                w_rdErrAcc = 1'b0;
                w_state    = IDLE;
            end
            WR_REQ: begin
                // AW and W complete independently; B is only opened once both have gone.
                w_awvalid = r_awvalid & ~m_awready;
                w_wvalid  = r_wvalid & ~m_wready;
                if (!w_awvalid && !w_wvalid) begin
                    w_bready = 1'b1;
                    w_state  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    w_bready  = 1'b0;
                    w_wrReady = 1'b1;
                    w_wrErr   = w_bErr;
                    w_state   = WR_DONE;
                end
            end
            WR_DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rdData    <= '0;
            r_rdReady   <= 1'b0;
            r_rdErr     <= 1'b0;
            r_rdErrAcc  <= 1'b0;
            r_firstBeat <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_wrReady   <= 1'b0;
            r_wrErr     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_araddr    <= w_araddr;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_rdData    <= w_rdData;
            r_rdReady   <= w_rdReady;
            r_rdErr     <= w_rdErr;
            r_rdErrAcc  <= w_rdErrAcc;
            r_firstBeat <= w_firstBeat;
            r_awaddr    <= w_awaddr;
            r_awvalid   <= w_awvalid;
            r_wdata     <= w_wdata;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_wrReady   <= w_wrReady;
            r_wrErr     <= w_wrErr;
        end
    end

    assign RdRqData  = r_rdData;
    assign RdRqReady = r_rdReady;
    assign RdRqErr   = r_rdErr;
    assign WrRqReady = r_wrReady;
    assign WrRqErr   = r_wrErr;

    assign m_arid    = AXI_ID;
    assign m_araddr  = r_araddr;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b100;
    assign m_arburst = 2'b01;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

    assign m_awid    = AXI_ID;
    assign m_awaddr  = r_awaddr;
    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'b100;
    assign m_awburst = 2'b01;
    assign m_awvalid = r_awvalid;

    assign m_wdata   = r_wdata;
    assign m_wstrb   = 16'hFFFF;
    assign m_wlast   = 1'b1;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;

endmodule

// File: doc/pcie_axi_req_bridge.md
# pcie_axi_req_bridge

Converts the single-outstanding read/write request interface driven by the PCIe sub-controller (RdRq*/WrRq*) into single-beat AXI4 master transactions and returns one-cycle completion pulses with data and error status. Sits directly downstream of the sub-controller and upstream of the AXI-MM interconnect. Only one transaction, read or write, is ever in flight.

## Interface
Parameters:
- AXI_ID, 4'h0, value driven on arid/awid
- ID_W, 4, width of arid/awid/rid/bid

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- RdRqValid  in  1  read request strobe
- RdRqAddr  in  64  read byte address
- RdRqData  out  128  read data, valid while RdRqReady=1
- RdRqReady  out  1  one-cycle read completion pulse
- RdRqErr  out  1  read error, qualified by RdRqReady
- WrRqValid  in  1  write request strobe
- WrRqAddr  in  64  write byte address
- WrRqData  in  128  write data
- WrRqReady  out  1  one-cycle write completion pulse
- WrRqErr  out  1  write error, qualified by WrRqReady
- m_arid/m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid  out  ID_W/64/8/3/2/1  AXI AR channel
- m_arready  in  1
- m_rid/m_rdata/m_rresp/m_rlast/m_rvalid  in  ID_W/128/2/1/1  AXI R channel
- m_rready  out  1
- m_awid/m_awaddr/m_awlen/m_awsize/m_awburst/m_awvalid  out  ID_W/64/8/3/2/1  AXI AW channel
- m_awready  in  1
- m_wdata/m_wstrb/m_wlast/m_wvalid  out  128/16/1/1  AXI W channel
- m_wready  in  1
- m_bid/m_bresp/m_bvalid  in  ID_W/2/1  AXI B channel
- m_bready  out  1

## Operation
- Constants: arlen/awlen=0, arsize/awsize=3'b100, arburst/awburst=2'b01, wstrb=16'hFFFF, wlast=1, arid/awid=AXI_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RD_DONE, WR_DONE.
- IDLE: RdRqValid=1 -> latch RdRqAddr into m_araddr, m_arvalid<=1, go RD_ADDR. Else WrRqValid=1 -> latch address/data, m_awvalid<=1, m_wvalid<=1, go WR_REQ. Both valid same cycle: read wins, write dropped (the controller re-asserts it).
- RdRqValid/WrRqValid are sampled only in IDLE; ignored in every other state (the controller re-strobes valid while waiting).
- RD_ADDR: m_arvalid held until m_arready; then m_arvalid<=0, m_rready<=1, go RD_DATA.
- RD_DATA: on m_rvalid&m_rready: first beat captures m_rdata into RdRqData; err flag |= (m_rresp!=2'b00) | (m_rid!=AXI_ID) | ~m_rlast. Beats continue to be drained until m_rlast=1; then m_rready<=0, go RD_DONE.
- RD_DONE: RdRqReady=1, RdRqErr=err flag, for exactly one cycle; go IDLE, clear err flag.
- WR_REQ: m_awvalid and m_wvalid dropped independently on their own ready; when both have handshaked (same or different cycles), m_bready<=1, go WR_RESP.
- WR_RESP: on m_bvalid: WrRqErr flag = (m_bresp!=2'b00) | (m_bid!=AXI_ID); m_bready<=0, go WR_DONE.
- WR_DONE: WrRqReady=1, WrRqErr valid, one cycle; go IDLE.
- No timeout; bridge waits indefinitely on AXI.

## Timing
- All outputs registered. Reset values: every valid/ready/Err/Ready 0, m_araddr/m_awaddr/m_wdata/RdRqData 0, state IDLE.
- Reset mid-transaction: immediate return to IDLE, all valids deasserted asynchronously; no completion pulse issued.
- Read latency with zero-wait AXI: request sampled cycle 0, arvalid cycle 1, rvalid accepted cycle 2, RdRqReady cycle 3. Write: awvalid/wvalid cycle 1, bvalid accepted cycle 2, WrRqReady cycle 3.
- RdRqData holds its value until the next read captures; Err outputs are 0 whenever the matching Ready is 0.
- A new request may be accepted on the cycle immediately after a *_DONE cycle; a Valid present during *_DONE is ignored.
- AXI valids never drop before handshake; addresses/data stable while valid.

## Test plan
- Read, zero-wait slave, addr 64'h10, rdata 128'hA5..A5, OKAY -> arvalid cycle 1 with araddr 64'h10, RdRqReady=1 cycle 3, RdRqData=128'hA5..A5, RdRqErr=0.
- Read with arready delayed 5 cycles and rresp=SLVERR -> arvalid held 5 cycles, single RdRqReady pulse with RdRqErr=1; RdRqValid re-strobed every cycle meanwhile causes no second AR.
- Write addr 64'h20 data 128'h1, awready 2 cycles before wready -> awvalid drops first, wvalid held until wready, bready only after both, WrRqReady=1 one cycle, WrRqErr=0.
- Simultaneous RdRqValid and WrRqValid in IDLE -> only AR issued; write accepted on its next strobe after RD_DONE.
- Read returning two beats (rlast=0 then 1) -> both drained, RdRqData = first beat, RdRqErr=1.
- rst_n asserted while in WR_RESP -> all AXI valids and m_bready 0 immediately, no WrRqReady; after release a read completes normally.
